// File: rtl/edn_pkg.sv
// edn_pkg
// Shared bus widths for the EDN endpoint path.
//   ENDPOINT_BUS_WIDTH : width of one chunk handed to a local entropy consumer
//   GADGET_OUT_WIDTH   : width of one word delivered by the req/ack width-adapter gadget
package edn_pkg;

  localparam int ENDPOINT_BUS_WIDTH = 32;
  localparam int GADGET_OUT_WIDTH   = 4 * ENDPOINT_BUS_WIDTH;

endpackage

// File: rtl/edn_entropy_dispenser.sv
// edn_entropy_dispenser
// Pre-fetches up to two InW-bit entropy words from the EDN width-adapter gadget and hands them
// out as OutW-bit chunks (LSB chunk first) over valid/ready, each tagged with the FIPS flag of
// its source word. Refills itself with one outstanding req/ack handshake at a time.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   edn_req_o   request to gadget, held high until edn_ack_i
//   edn_ack_i   one-cycle gadget ack; edn_data_i/edn_fips_i valid only then
//   edn_data_i  gadget word
//   edn_fips_i  gadget FIPS flag
//   flush_i     discard all held and in-flight entropy
//   rvalid_o    a chunk is being presented
//   rready_i    consumer accepts the presented chunk
//   rdata_o     presented chunk (0 when rvalid_o is low)
//   rfips_o     FIPS flag of the word the chunk comes from (0 when rvalid_o is low)
//   slots_o     number of full word slots (0..2)
module edn_entropy_dispenser
  import edn_pkg::*;
#(
  parameter int InW  = GADGET_OUT_WIDTH,
  parameter int OutW = ENDPOINT_BUS_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            edn_req_o,
  input  logic            edn_ack_i,
  input  logic [InW-1:0]  edn_data_i,
  input  logic            edn_fips_i,
  input  logic            flush_i,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic [OutW-1:0] rdata_o,
  output logic            rfips_o,
  output logic [1:0]      slots_o
);

  localparam int NumChunks = InW / OutW;
  localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  if ((InW % OutW) != 0 || NumChunks < 1) begin : gen_bad_width
    $error("InW must be a non-zero multiple of OutW");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } reqState_e;

  reqState_e       state_q, state_d;
  logic            req_q, req_d;
  logic [InW-1:0]  slotData_q [2];
  logic            slotFips_q [2];
  logic            wrPtr_q, wrPtr_d;
  logic            rdPtr_q, rdPtr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      slots_q, slots_d;

  logic            pop;
  logic            lastPop;
  logic            ackWrite;
  logic [InW-1:0]  curWord;

  // Handshake qualifiers. An ack only lands in a slot when we asked for it in REQ and no flush
  // is discarding it in the same cycle.
  assign pop      = rvalid_o && rready_i;
  assign lastPop  = pop && (idx_q == LastIdx);
  assign ackWrite = (state_q == REQ) && edn_ack_i && !flush_i;

  // Output side: the head slot is always the one being chunked; outputs are forced to zero
  // when nothing is held so stale slot contents never leak.
  assign curWord   = slotData_q[rdPtr_q];
  assign rvalid_o  = (slots_q != 2'd0);
  assign rdata_o   = rvalid_o ? curWord[int'(idx_q)*OutW +: OutW] : '0;
  assign rfips_o   = rvalid_o ? slotFips_q[rdPtr_q] : 1'b0;
  assign slots_o   = slots_q;
  assign edn_req_o = req_q;

  // Request FSM. Once a request is up it cannot be withdrawn, so a flush while waiting moves
  // to DISCARD, which still completes the handshake but throws the word away. Leaving through
  // IDLE guarantees the request drops for at least one cycle after every ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (slots_q != 2'd2) state_d = REQ;
      REQ: begin
        if (edn_ack_i)    state_d = IDLE;
        else if (flush_i) state_d = DISCARD;
      end
      DISCARD: if (edn_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  // Slot bookkeeping. A write and a last-chunk pop in the same cycle cancel in the count;
  // flush clears everything and wins over any pop or write.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    idx_d   = idx_q;
    slots_d = slots_q;
    if (flush_i) begin
      wrPtr_d = 1'b0;
      rdPtr_d = 1'b0;
      idx_d   = '0;
      slots_d = 2'd0;
    end else begin
      if (ackWrite) wrPtr_d = ~wrPtr_q;
      if (pop) begin
        if (lastPop) begin
          idx_d   = '0;
          rdPtr_d = ~rdPtr_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      unique case ({ackWrite, lastPop})
        2'b10:   slots_d = slots_q + 2'd1;
        2'b01:   slots_d = slots_q - 2'd1;
        default: slots_d = slots_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      idx_q   <= '0;
      slots_q <= 2'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      idx_q   <= idx_d;
      slots_q <= slots_d;
    end
  end

  // Word storage needs no reset: slot contents are only visible while the slot is counted full.
  always_ff @(posedge clk_i) begin
    if (ackWrite) begin
      slotData_q[wrPtr_q] <= edn_data_i;
      slotFips_q[wrPtr_q] <= edn_fips_i;
    end
  end

  // Protocol and invariant checks.
  ackOnlyWhenRequested: assert property (@(posedge clk_i) disable iff (rst_i)
    edn_ack_i |-> (state_q != IDLE));
  reqHeldUntilAck: assert property (@(posedge clk_i) disable iff (rst_i)
    (edn_req_o && !edn_ack_i) |=> edn_req_o);
  slotsInRange: assert property (@(posedge clk_i) disable iff (rst_i)
    slots_q <= 2'd2);
  dataStableUnderStall: assert property (@(posedge clk_i) disable iff (rst_i)
    (rvalid_o && !rready_i && !flush_i) |=> $stable(rdata_o));

endmodule

// File: tb/tb_edn_entropy_dispenser.sv
// tb_edn_entropy_dispenser
// Directed bench for edn_entropy_dispenser: a 128->32 instance exercises refill, backpressure,
// FIPS tagging, flush and ack/pop collisions; a 32->32 instance covers one chunk per word.
module tb_edn_entropy_dispenser;

  logic         clk = 1'b0;
  logic         rst;

  logic         ednReq;
  logic         ednAck;
  logic [127:0] ednData;
  logic         ednFips;
  logic         flush;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic         rfips;
  logic [1:0]   slots;

  logic         nReq;
  logic         nAck;
  logic [31:0]  nData;
  logic         nFips;
  logic         nFlush;
  logic         nRvalid;
  logic         nRready;
  logic [31:0]  nRdata;
  logic         nRfips;
  logic [1:0]   nSlots;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] WordA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WordB = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] WordC = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] WordD = 128'hD00D0003_D00D0002_D00D0001_D00D0000;
  localparam logic [127:0] WordE = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
  localparam logic [127:0] WordF = 128'hF00F0003_F00F0002_F00F0001_F00F0000;
  localparam logic [127:0] WordG = 128'h66660003_66660002_66660001_66660000;
  localparam logic [127:0] WordH = 128'h77770003_77770002_77770001_77770000;
  localparam logic [127:0] WordI = 128'h99990003_99990002_99990001_99990000;

  edn_entropy_dispenser #(.InW(128), .OutW(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .edn_req_o  (ednReq),
    .edn_ack_i  (ednAck),
    .edn_data_i (ednData),
    .edn_fips_i (ednFips),
    .flush_i    (flush),
    .rvalid_o   (rvalid),
    .rready_i   (rready),
    .rdata_o    (rdata),
    .rfips_o    (rfips),
    .slots_o    (slots)
  );

  edn_entropy_dispenser #(.InW(32), .OutW(32)) dutNarrow (
    .clk_i      (clk),
    .rst_i      (rst),
    .edn_req_o  (nReq),
    .edn_ack_i  (nAck),
    .edn_data_i (nData),
    .edn_fips_i (nFips),
    .flush_i    (nFlush),
    .rvalid_o   (nRvalid),
    .rready_i   (nRready),
    .rdata_o    (nRdata),
    .rfips_o    (nRfips),
    .slots_o    (nSlots)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the wide instance for one clock; ack and flush are single-cycle pulses, rready is a
  // level that stays as given. Returns 1 time unit after the edge, where outputs are sampled.
  task automatic applyStimulus(input logic ack, input logic [127:0] data, input logic fips,
                               input logic flsh, input logic rdy);
    ednAck  = ack;
    ednData = data;
    ednFips = fips;
    flush   = flsh;
    rready  = rdy;
    @(posedge clk);
    #1;
    ednAck = 1'b0;
    flush  = 1'b0;
  endtask

  // Same as applyStimulus, for the one-chunk-per-word instance.
  task automatic applyStimulusNarrow(input logic ack, input logic [31:0] data, input logic fips,
                                     input logic rdy);
    nAck    = ack;
    nData   = data;
    nFips   = fips;
    nRready = rdy;
    @(posedge clk);
    #1;
    nAck = 1'b0;
  endtask

  // Drain one whole word from the wide instance, checking every chunk and its FIPS tag.
  task automatic popWord(input string tag, input logic [127:0] word, input logic fips);
    logic [127:0] w;
    w = word;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_c%0d", tag, i), {96'd0, rdata}, {96'd0, w[i*32 +: 32]});
      checkOutput($sformatf("%s_fips%0d", tag, i), {127'd0, rfips}, {127'd0, fips});
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    rready = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    ednAck  = 1'b0;
    ednData = '0;
    ednFips = 1'b0;
    flush   = 1'b0;
    rready  = 1'b0;
    nAck    = 1'b0;
    nData   = '0;
    nFips   = 1'b0;
    nFlush  = 1'b0;
    nRready = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_req",    {127'd0, ednReq}, 128'd0);
    checkOutput("rst_rvalid", {127'd0, rvalid}, 128'd0);
    checkOutput("rst_rdata",  {96'd0, rdata},   128'd0);
    checkOutput("rst_rfips",  {127'd0, rfips},  128'd0);
    checkOutput("rst_slots",  {126'd0, slots},  128'd0);
    checkOutput("rst_nreq",   {127'd0, nReq},   128'd0);

    $display("[TB] first refill and chunk order");
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_req_up", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_req_held", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b1, WordA, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_rvalid", {127'd0, rvalid}, 128'd1);
    checkOutput("t1_slots",  {126'd0, slots},  128'd1);
    checkOutput("t1_req_dn", {127'd0, ednReq}, 128'd0);
    popWord("t1_A", WordA, 1'b1);
    checkOutput("t1_empty", {127'd0, rvalid}, 128'd0);
    checkOutput("t1_rdata0", {96'd0, rdata}, 128'd0);

    $display("[TB] backpressure fills both slots");
    applyStimulus(1'b1, WordB, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_req_gap", {127'd0, ednReq}, 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_req_again", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b1, WordC, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_slots2", {126'd0, slots}, 128'd2);
    checkOutput("t2_req_full", {127'd0, ednReq}, 128'd0);
    checkOutput("t2_stall_d0", {96'd0, rdata}, {96'd0, WordB[31:0]});
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_req_full2", {127'd0, ednReq}, 128'd0);
    checkOutput("t2_stall_d1", {96'd0, rdata}, {96'd0, WordB[31:0]});
    popWord("t3_B", WordB, 1'b1);
    checkOutput("t2_slots1", {126'd0, slots}, 128'd1);
    checkOutput("t2_req_lag", {127'd0, ednReq}, 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_req_re", {127'd0, ednReq}, 128'd1);
    popWord("t3_C", WordC, 1'b0);

    $display("[TB] flush with request pending");
    applyStimulus(1'b1, WordD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_pre_slots", {126'd0, slots}, 128'd1);
    checkOutput("t4_pre_req", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_rvalid", {127'd0, rvalid}, 128'd0);
    checkOutput("t4_rdata", {96'd0, rdata}, 128'd0);
    checkOutput("t4_slots", {126'd0, slots}, 128'd0);
    checkOutput("t4_req_kept", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b1, WordE, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_drop_rvalid", {127'd0, rvalid}, 128'd0);
    checkOutput("t4_drop_slots", {126'd0, slots}, 128'd0);
    checkOutput("t4_drop_req", {127'd0, ednReq}, 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_fresh_req", {127'd0, ednReq}, 128'd1);
    applyStimulus(1'b1, WordF, 1'b1, 1'b0, 1'b0);
    popWord("t4_F", WordF, 1'b1);

    $display("[TB] flush together with ack");
    applyStimulus(1'b1, WordG, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_slots", {126'd0, slots}, 128'd0);
    checkOutput("t5_rvalid", {127'd0, rvalid}, 128'd0);
    checkOutput("t5_req_idle", {127'd0, ednReq}, 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_req_new", {127'd0, ednReq}, 128'd1);

    $display("[TB] ack coincident with last-chunk pop");
    applyStimulus(1'b1, WordH, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_req", {127'd0, ednReq}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6_H_c%0d", i), {96'd0, rdata}, {96'd0, WordH[i*32 +: 32]});
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t6_H_c3", {96'd0, rdata}, {96'd0, WordH[127:96]});
    applyStimulus(1'b1, WordI, 1'b1, 1'b0, 1'b1);
    rready = 1'b0;
    checkOutput("t6_slots", {126'd0, slots}, 128'd1);
    popWord("t6_I", WordI, 1'b1);
    checkOutput("t6_end_slots", {126'd0, slots}, 128'd0);

    $display("[TB] one chunk per word");
    checkOutput("t6n_req", {127'd0, nReq}, 128'd1);
    applyStimulusNarrow(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    checkOutput("t6n_rdata1", {96'd0, nRdata}, 128'hA5A5_0001);
    checkOutput("t6n_rfips1", {127'd0, nRfips}, 128'd1);
    applyStimulusNarrow(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6n_req2", {127'd0, nReq}, 128'd1);
    applyStimulusNarrow(1'b1, 32'h5A5A_0002, 1'b0, 1'b1);
    checkOutput("t6n_slots", {126'd0, nSlots}, 128'd1);
    checkOutput("t6n_rdata2", {96'd0, nRdata}, 128'h5A5A_0002);
    checkOutput("t6n_rfips2", {127'd0, nRfips}, 128'd0);
    applyStimulusNarrow(1'b0, '0, 1'b0, 1'b1);
    nRready = 1'b0;
    checkOutput("t6n_empty", {127'd0, nRvalid}, 128'd0);
    checkOutput("t6n_slots0", {126'd0, nSlots}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
